// File: rtl/dense_pkg.sv
// Shared types and default sizing for the dense-layer bias/saturation stage.
package dense_pkg;

    // Per-word control flow: accept accumulator, fetch bias, present result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_OUT_WIDTH   = 16;
    localparam int DEF_NUM_NEURONS = 10;

endpackage

// File: rtl/dense_bias_add_sat.sv
// Combinational signed saturation from IN_W bits down to OUT_W bits.
module sat_signed #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    generate
        if (IN_W > OUT_W) begin : g_narrow
            // Value fits when all bits from the output sign bit upward agree.
            function automatic logic signed [OUT_W-1:0] sat(input logic signed [IN_W-1:0] x);
                logic [IN_W-OUT_W:0] top;
                top = x[IN_W-1:OUT_W-1];
                if ((&top) || (~|top))
                    return x[OUT_W-1:0];
                else if (x[IN_W-1])
                    return {1'b1, {(OUT_W-1){1'b0}}};
                else
                    return {1'b0, {(OUT_W-1){1'b1}}};
            endfunction

            // Clamp to the representable output range.
            always_comb begin
                dout = sat(din);
            end
        end else begin : g_wide
            // Output at least as wide as input: plain sign extension.
            always_comb begin
                dout = OUT_W'(din);
            end
        end
    endgenerate

endmodule

// File: rtl/dense_bias_add.sv
// Adds a per-neuron bias from an external ROM to each accumulator word,
// saturates (optionally ReLUs) and presents the result with its neuron index.
module dense_bias_add
    import dense_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int RELU_EN     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ACC_WIDTH-1:0]  s_acc,
    output logic                  rom_ena,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic [ADDR_WIDTH-1:0] m_idx,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_NEURONS - 1);

    state_t                        state_q;
    state_t                        state_d;
    logic [ADDR_WIDTH-1:0]         idx;
    logic signed [ACC_WIDTH-1:0]   acc_p0;
    logic signed [ACC_WIDTH:0]     sum_p1;
    logic signed [OUT_WIDTH-1:0]   sat_p1;

    function automatic logic signed [OUT_WIDTH-1:0] relu(input logic signed [OUT_WIDTH-1:0] x);
        if ((RELU_EN != 0) && (x < 0))
            return '0;
        return x;
    endfunction

    // Stage p0 -> p1: bias arrives from the ROM one cycle after the accept.
    always_comb begin
        sum_p1 = $signed({acc_p0[ACC_WIDTH-1], acc_p0})
               + $signed({{(ACC_WIDTH+1-DATA_WIDTH){rom_q[DATA_WIDTH-1]}}, rom_q});
    end

    sat_signed #(
        .IN_W  (ACC_WIDTH + 1),
        .OUT_W (OUT_WIDTH)
    ) u_sat (
        .din  (sum_p1),
        .dout (sat_p1)
    );

    // Next-state and handshake outputs; reset forces both enables low.
    always_comb begin
        state_d  = state_q;
        s_ready  = 1'b0;
        rom_ena  = 1'b0;
        rom_addr = idx;
        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                rom_ena = s_valid;
                if (s_valid)
                    state_d = FETCH;
            end
            FETCH: state_d = OUT;
            OUT: begin
                if (m_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            s_ready = 1'b0;
            rom_ena = 1'b0;
            state_d = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Accumulator latch, result register and neuron index counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p0  <= '0;
            idx     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_idx   <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid)
                        acc_p0 <= $signed(s_acc);
                end
                FETCH: begin
                    m_data  <= relu(sat_p1);
                    m_idx   <= idx;
                    m_last  <= (idx == LAST_IDX);
                    m_valid <= 1'b1;
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_bias_add.sv
// Directed bench for dense_bias_add: one plain instance and one with ReLU,
// sharing stimulus, each with its own registered bias ROM model.
module tb_dense_bias_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [23:0] s_acc;
    logic        m_ready;

    logic        s_ready0, rom_ena0, m_valid0, m_last0;
    logic [7:0]  rom_addr0, rom_q0, m_idx0;
    logic [15:0] m_data0;

    logic        s_ready1, rom_ena1, m_valid1, m_last1;
    logic [7:0]  rom_addr1, rom_q1, m_idx1;
    logic [15:0] m_data1;

    logic [7:0]  rom [0:255];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Registered ROM with zero output when not enabled.
    always @(posedge clk) begin
        rom_q0 <= rom_ena0 ? rom[rom_addr0] : 8'h00;
        rom_q1 <= rom_ena1 ? rom[rom_addr1] : 8'h00;
    end

    dense_bias_add #(.RELU_EN(0)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_acc(s_acc),
        .rom_ena(rom_ena0), .rom_addr(rom_addr0), .rom_q(rom_q0),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_idx(m_idx0),
        .m_last(m_last0)
    );

    dense_bias_add #(.RELU_EN(1)) dut_relu (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_acc(s_acc),
        .rom_ena(rom_ena1), .rom_addr(rom_addr1), .rom_q(rom_q1),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_idx(m_idx1),
        .m_last(m_last1)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word: accept, FETCH, result, optional backpressure, handshake.
    task automatic word(input int acc, input int addr_exp, input int exp0, input int exp1,
                        input int last_exp, input int hold);
        s_valid = 1'b1;
        s_acc   = acc[23:0];
        #1;
        chk("s_ready_idle", s_ready0, 1);
        chk("rom_ena_accept", rom_ena0, 1);
        chk("rom_addr", rom_addr0, addr_exp);
        tick();
        s_valid = (hold > 0);
        #1;
        chk("m_valid_fetch", m_valid0, 0);
        chk("s_ready_fetch", s_ready0, 0);
        chk("rom_ena_fetch", rom_ena0, 0);
        tick();
        chk("m_valid_out", m_valid0, 1);
        chk("m_data", $signed(m_data0), exp0);
        chk("m_data_relu", $signed(m_data1), exp1);
        chk("m_idx", m_idx0, addr_exp);
        chk("m_last", m_last0, last_exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_m_valid", m_valid0, 1);
            chk("bp_m_data", $signed(m_data0), exp0);
            chk("bp_s_ready", s_ready0, 0);
            chk("bp_rom_ena", rom_ena0, 0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        #1;
        chk("m_valid_after_hs", m_valid0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'h05;
        rom[1] = 8'h7F;
        rom[2] = 8'h80;
        rom[3] = 8'h03;
        rom[4] = 8'h03;
        rom[5] = 8'hFF;
        rom[6] = 8'h80;
        rom[7] = 8'h01;
        rom[8] = 8'h00;
        rom[9] = 8'h10;

        rst = 1'b1; s_valid = 1'b1; s_acc = 24'd0; m_ready = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", s_ready0, 0);
        chk("rst_rom_ena", rom_ena0, 0);
        chk("rst_m_valid", m_valid0, 0);
        chk("rst_m_data", m_data0, 0);
        chk("rst_m_idx", m_idx0, 0);
        chk("rst_m_last", m_last0, 0);
        rst = 1'b0; s_valid = 1'b0;
        tick();

        // Frame: idx 0..9, then wrap to 0.
        word(256,     0, 261,    261,   0, 0);
        word(40000,   1, 32767,  32767, 0, 5);
        word(-40000,  2, -32768, 0,     0, 0);
        word(-10,     3, -7,     0,     0, 0);
        word(10,      4, 13,     13,    0, 0);
        word(0,       5, -1,     0,     0, 0);
        word(32895,   6, 32767,  32767, 0, 0);
        word(32767,   7, 32767,  32767, 0, 0);
        word(-32769,  8, -32768, 0,     0, 0);
        word(-32784,  9, -32768, 0,     1, 0);
        word(-5,      0, 0,      0,     0, 0);

        // Reset while a result is pending in OUT (idx is 1 beforehand).
        s_valid = 1'b1; s_acc = 24'd7;
        tick();
        s_valid = 1'b0;
        tick();
        chk("pre_rst_m_valid", m_valid0, 1);
        rst = 1'b1;
        m_ready = 1'b1;
        tick();
        chk("mid_rst_s_ready", s_ready0, 0);
        tick();
        chk("mid_rst_m_valid", m_valid0, 0);
        rst = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("post_rst_s_ready", s_ready0, 1);
        chk("post_rst_rom_addr", rom_addr0, 0);
        tick();
        chk("post_rst_no_hs", m_valid0, 0);
        word(100, 0, 105, 105, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dense_bias_add.md
DENSE_BIAS_ADD -- requirements
Module: dense_bias_add

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed bias word width, equal to the bias ROM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: bias ROM address width.
REQ-003 SHALL have parameter ACC_WIDTH, default 24: signed accumulator input width.
REQ-004 SHALL have parameter OUT_WIDTH, default 16: signed result width.
REQ-005 SHALL have parameter NUM_NEURONS, default 10: output neurons per frame, 1..2**ADDR_WIDTH.
REQ-006 SHALL have parameter RELU_EN, default 0: when 1, negative results are clamped to 0.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port s_valid, input, 1 bit: accumulator word valid.
REQ-010 SHALL have port s_ready, output, 1 bit: block can accept an accumulator word.
REQ-011 SHALL have port s_acc, input, ACC_WIDTH bits: signed dot-product sum.
REQ-012 SHALL have port rom_ena, output, 1 bit: bias ROM read enable.
REQ-013 SHALL have port rom_addr, output, ADDR_WIDTH bits: bias ROM address.
REQ-014 SHALL have port rom_q, input, DATA_WIDTH bits: bias ROM data, registered, valid one cycle after rom_ena is sampled high.
REQ-015 SHALL have port m_valid, output, 1 bit: result valid.
REQ-016 SHALL have port m_ready, input, 1 bit: downstream accepts the result.
REQ-017 SHALL have port m_data, output, OUT_WIDTH bits: signed biased and saturated result.
REQ-018 SHALL have port m_idx, output, ADDR_WIDTH bits: neuron index of m_data.
REQ-019 SHALL have port m_last, output, 1 bit: m_idx equals NUM_NEURONS-1.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH and OUT.
REQ-021 IDLE: s_ready=1; rom_ena=s_valid (combinational); rom_addr=idx counter; on s_valid, latch s_acc and go to FETCH.
REQ-022 FETCH: s_ready=0 and rom_ena=0; compute result from latched acc and rom_q; register m_data, m_idx and m_last; set m_valid=1; go to OUT.
REQ-023 OUT: hold m_valid, m_data, m_idx and m_last stable while m_ready=0; on m_ready, clear m_valid, advance idx, go to IDLE.
REQ-024 Latency SHALL be exactly 2 cycles from accept edge to m_valid high; minimum 3 cycles per word.
REQ-025 idx SHALL wrap from NUM_NEURONS-1 to 0 on the handshake of the word with m_last=1.
REQ-026 Arithmetic: sign-extend rom_q and latched acc to ACC_WIDTH+1 bits, then add.
REQ-027 The sum SHALL saturate to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1].
REQ-028 If RELU_EN=1, a negative saturated value SHALL become 0.
REQ-029 s_ready SHALL be 0 in FETCH and OUT; an s_valid held there is not consumed.
REQ-030 rom_ena SHALL be 0 outside an IDLE accept cycle, so that rom_q reads 0 when unused.

Reset
REQ-031 rst SHALL set state=IDLE, idx=0, m_valid=0, m_data=0, m_idx=0, m_last=0 and latched acc=0.
REQ-032 rst asserted in any state, including mid-OUT, SHALL discard the in-flight word, with no handshake on the next cycle.
REQ-033 During rst, s_ready SHALL be 0 and rom_ena SHALL be 0.

Structure
REQ-034 Package dense_pkg SHALL hold the FSM state enum and default width and neuron-count constants.
REQ-035 Saturation SHALL be a sub-module sat_signed, parameterised by input and output widths, purely combinational.
REQ-036 The design SHALL have no memories; the ROM stays external.

Verification
REQ-037 Reset: assert rst for 2 cycles during OUT -> m_valid=0, next s_ready=1, next rom_addr=0.
REQ-038 Basic: acc=256, bias at addr 0=0x05 -> m_data=261, m_idx=0, m_valid exactly 2 cycles after accept.
REQ-039 Saturation: acc=40000, bias 0x7F -> 32767; acc=-40000, bias 0x80 -> -32768.
REQ-040 ReLU: RELU_EN=1, acc=-10, bias 3 -> m_data=0; acc=10, bias 3 -> m_data=13.
REQ-041 Backpressure: hold m_ready=0 for 5 cycles -> m_data stable, s_ready=0, rom_ena=0 throughout.
REQ-042 Frame wrap: 11 back-to-back words -> rom_addr 0..9, m_last on the 10th, 11th word uses addr 0 with m_idx=0.
